// File: rtl/hdmi_timing_ctrl.sv
// Video timing scheduler: horizontal/vertical segment FSMs producing sync, DE, coordinates and strobes.
// Define HDMI_TIMING_STATUS_EN to add the frame_cnt and vblank status outputs.
module hdmi_timing_ctrl #(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic          clock50,
    input  logic          reset_n,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef HDMI_TIMING_STATUS_EN
    ,
    output logic [7:0]    frame_cnt,
    output logic          vblank
`endif
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FP     = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BP     = 2'd3
    } seg_t;

    localparam longint SEG_MAX = longint'(1) << CW;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_ACTIVE > SEG_MAX || H_FP > SEG_MAX || H_SYNC > SEG_MAX || H_BP > SEG_MAX ||
        V_ACTIVE > SEG_MAX || V_FP > SEG_MAX || V_SYNC > SEG_MAX || V_BP > SEG_MAX) begin : g_bad_len
        $error("hdmi_timing_ctrl: every segment length must be in 1..2**CW");
    end

    localparam logic [CW-1:0] H_ACT_LAST  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] H_FP_LAST   = CW'(H_FP - 1);
    localparam logic [CW-1:0] H_SYNC_LAST = CW'(H_SYNC - 1);
    localparam logic [CW-1:0] H_BP_LAST   = CW'(H_BP - 1);
    localparam logic [CW-1:0] V_ACT_LAST  = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] V_FP_LAST   = CW'(V_FP - 1);
    localparam logic [CW-1:0] V_SYNC_LAST = CW'(V_SYNC - 1);
    localparam logic [CW-1:0] V_BP_LAST   = CW'(V_BP - 1);

    function automatic seg_t seg_next(input seg_t s);
        case (s)
            ST_ACTIVE: seg_next = ST_FP;
            ST_FP:     seg_next = ST_SYNC;
            ST_SYNC:   seg_next = ST_BP;
            default:   seg_next = ST_ACTIVE;
        endcase
    endfunction

    function automatic logic [CW-1:0] h_last(input seg_t s);
        case (s)
            ST_ACTIVE: h_last = H_ACT_LAST;
            ST_FP:     h_last = H_FP_LAST;
            ST_SYNC:   h_last = H_SYNC_LAST;
            default:   h_last = H_BP_LAST;
        endcase
    endfunction

    function automatic logic [CW-1:0] v_last(input seg_t s);
        case (s)
            ST_ACTIVE: v_last = V_ACT_LAST;
            ST_FP:     v_last = V_FP_LAST;
            ST_SYNC:   v_last = V_SYNC_LAST;
            default:   v_last = V_BP_LAST;
        endcase
    endfunction

    seg_t          h_state, h_state_nxt, v_state, v_state_nxt;
    logic [CW-1:0] h_cnt, h_cnt_nxt, v_cnt, v_cnt_nxt;
    logic          line_end;

    // Vertical axis advances only on the last back-porch pixel of a line.
    assign line_end = pix_en && (h_state == ST_BP) && (h_cnt == H_BP_LAST);

    always_comb begin
        h_state_nxt = h_state;
        h_cnt_nxt   = h_cnt;
        v_state_nxt = v_state;
        v_cnt_nxt   = v_cnt;
        if (pix_en) begin
            if (h_cnt == h_last(h_state)) begin
                h_state_nxt = seg_next(h_state);
                h_cnt_nxt   = '0;
            end else begin
                h_cnt_nxt = h_cnt + 1'b1;
            end
        end
        if (line_end) begin
            if (v_cnt == v_last(v_state)) begin
                v_state_nxt = seg_next(v_state);
                v_cnt_nxt   = '0;
            end else begin
                v_cnt_nxt = v_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            h_state <= ST_ACTIVE;
            v_state <= ST_ACTIVE;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            h_state <= h_state_nxt;
            v_state <= v_state_nxt;
            h_cnt   <= h_cnt_nxt;
            v_cnt   <= v_cnt_nxt;
        end
    end

    // Registered-state decode; only the strobes look at pix_en directly.
    assign hsync       = (h_state == ST_SYNC) ? H_POL : ~H_POL;
    assign vsync       = (v_state == ST_SYNC) ? V_POL : ~V_POL;
    assign de          = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
    assign x           = (h_state == ST_ACTIVE) ? h_cnt : '0;
    assign y           = (v_state == ST_ACTIVE) ? v_cnt : '0;
    assign line_start  = pix_en && de && (h_cnt == '0);
    assign frame_start = line_start && (v_cnt == '0);

`ifdef HDMI_TIMING_STATUS_EN
    logic frame_wrap;
    assign frame_wrap = line_end && (v_state == ST_BP) && (v_cnt == V_BP_LAST);
    assign vblank     = (v_state != ST_ACTIVE);

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 8'd0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Randomised pix_en bench for hdmi_timing_ctrl against a linear pixel-position model (8x6 toy raster).
module tb_hdmi_timing_ctrl;

    localparam int CW = 4;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic          clock50 = 1'b0;
    logic          reset_n = 1'b0;
    logic          pix_en  = 1'b1;
    logic          hsync, vsync, de, line_start, frame_start;
    logic [CW-1:0] x, y;
`ifdef HDMI_TIMING_STATUS_EN
    logic [7:0]    frame_cnt;
    logic          vblank;
`endif

    int   n_chk = 0;
    int   n_bad = 0;
    int   p     = 0;
    int   fcnt  = 0;
    logic en_prev = 1'b0;

    always #5 clock50 = ~clock50;

    hdmi_timing_ctrl #(
        .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut (
        .clock50     (clock50),
        .reset_n     (reset_n),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef HDMI_TIMING_STATUS_EN
        ,
        .frame_cnt   (frame_cnt),
        .vblank      (vblank)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s pos=%0d got=%0d exp=%0d", tag, p, got, exp);
        end
    endtask

    // Expected outputs from the linear pixel index p within the frame.
    task automatic chk_all(input string where);
        int hx, ln;
        bit hact, vact, hsy, vsy, ls;
        hx   = p % HT;
        ln   = p / HT;
        hact = (hx < HA);
        vact = (ln < VA);
        hsy  = (hx >= HA + HF) && (hx < HA + HF + HS);
        vsy  = (ln >= VA + VF) && (ln < VA + VF + VS);
        ls   = pix_en && hact && vact && (hx == 0);
        chk({where, "/de"},    int'(de),    int'(hact && vact));
        chk({where, "/x"},     int'(x),     hact ? hx : 0);
        chk({where, "/y"},     int'(y),     vact ? ln : 0);
        chk({where, "/hsync"}, int'(hsync), int'(!hsy));
        chk({where, "/vsync"}, int'(vsync), int'(!vsy));
        chk({where, "/lstart"}, int'(line_start),  int'(ls));
        chk({where, "/fstart"}, int'(frame_start), int'(ls && (ln == 0)));
`ifdef HDMI_TIMING_STATUS_EN
        chk({where, "/fcnt"},   int'(frame_cnt), fcnt);
        chk({where, "/vblank"}, int'(vblank),    int'(!vact));
`endif
    endtask

    task automatic step(input logic en, input string where);
        @(posedge clock50);
        #1;
        if (en_prev) begin
            if (p == FT - 1) fcnt = (fcnt + 1) % 256;
            p = (p + 1) % FT;
        end
        pix_en  = en;
        en_prev = en;
        #1;
        chk_all(where);
    endtask

    initial begin
        reset_n = 1'b0;
        pix_en  = 1'b1;
        en_prev = 1'b0;
        #2;
        chk_all("rst_en1");
        pix_en = 1'b0;
        #1;
        chk_all("rst_en0");
        pix_en = 1'b1;
        @(posedge clock50);
        #3;
        reset_n = 1'b1;
        en_prev = 1'b1;
        #1;
        chk_all("release");

        for (int i = 0; i < 2 * FT; i++) step(1'b1, "run");

        for (int i = 0; i < 3; i++) step(1'b1, "hold_pre");
        step(1'b0, "hold0");
        step(1'b0, "hold1");
        step(1'b1, "hold2");
        step(1'b1, "hold3");

        for (int i = 0; i < 400; i++) step(($urandom_range(0, 3) != 0), "rand");

        for (int i = 0; i < 2 * FT && p != 4 * HT + 5; i++) step(1'b1, "seek");
        #2;
        reset_n = 1'b0;
        #1;
        p       = 0;
        fcnt    = 0;
        en_prev = 1'b0;
        chk_all("arst");
        @(posedge clock50);
        #1;
        chk_all("arst_hold");
        #3;
        reset_n = 1'b1;
        pix_en  = 1'b1;
        en_prev = 1'b1;
        #1;
        chk_all("arst_rel");

        for (int i = 0; i < FT; i++) step(1'b1, "rerun");
        for (int i = 0; i < 300; i++) step(($urandom_range(0, 1) != 0), "rand2");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
